// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/writeback/forwarding inputs and decoded controls of the decode stage
interface decode_stage_if;
   logic        [15:0] IPCP2;
   logic        [15:0] pc_in;
   logic        [15:0] ir_in;
   logic               rf_write;
   logic        [2:0]  loadAddr;
   logic        [15:0] loadData;
   logic               RB_write;
   logic        [1:0]  comparatorMux1Control;
   logic        [1:0]  comparatorMux2Control;
   logic        [15:0] comparatorMuxForwardMEM;
   logic        [15:0] comparatorMuxForwardWB;
   logic               RegWrite;
   logic               ALUSrc;
   logic               MemWrite;
   logic               MemRead;
   logic        [2:0]  ALUOp;
   logic        [1:0]  RegStore;
   logic        [15:0] OPCP2;
   logic signed [15:0] Arg1;
   logic signed [15:0] Arg2;
   logic signed [15:0] Arg3;
   logic signed [15:0] Imm;
   logic        [2:0]  Rs1;
   logic        [2:0]  Rs2;
   logic        [2:0]  Rd;
   logic        [15:0] new_pc;
   logic               jump;
   modport master (
      output IPCP2, pc_in, ir_in, rf_write, loadAddr, loadData, RB_write,
             comparatorMux1Control, comparatorMux2Control,
             comparatorMuxForwardMEM, comparatorMuxForwardWB,
      input  RegWrite, ALUSrc, MemWrite, MemRead, ALUOp, RegStore, OPCP2,
             Arg1, Arg2, Arg3, Imm, Rs1, Rs2, Rd, new_pc, jump
   );
   modport slave (
      input  IPCP2, pc_in, ir_in, rf_write, loadAddr, loadData, RB_write,
             comparatorMux1Control, comparatorMux2Control,
             comparatorMuxForwardMEM, comparatorMuxForwardWB,
      output RegWrite, ALUSrc, MemWrite, MemRead, ALUOp, RegStore, OPCP2,
             Arg1, Arg2, Arg3, Imm, Rs1, Rs2, Rd, new_pc, jump
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file, instruction decode and in-stage branch resolution
module decode_stage (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave d
);
   logic [15:0] rf_q [8];
   logic [15:0] rf_d [8];
   logic [2:0]  opc;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] imm;
   logic        reg_write;
   logic        alu_src;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  alu_op;
   logic [1:0]  reg_store;
   logic        take;
   logic        live;
   assign opc  = d.ir_in[2:0];
   assign op_a = d.comparatorMux1Control[1] ? rf_q[d.ir_in[8:6]] :
                 d.comparatorMux1Control[0] ? d.comparatorMuxForwardWB : d.comparatorMuxForwardMEM;
   assign op_b = d.comparatorMux2Control[1] ? rf_q[d.ir_in[11:9]] :
                 d.comparatorMux2Control[0] ? d.comparatorMuxForwardWB : d.comparatorMuxForwardMEM;
   // writeback port updates the next register-file image; x0 is never written so it stays zero
   always_comb begin
      rf_d = rf_q;
      if (d.rf_write && d.loadAddr != 3'd0) rf_d[d.loadAddr] = d.loadData;
   end
   // register file state, cleared asynchronously while reset is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rf_q <= '{default: '0};
      else rf_q <= rf_d;
   end
   // opcode decode: controls, immediate and branch condition
   always_comb begin
      reg_write = 1'b0;
      alu_src   = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      alu_op    = 3'b000;
      reg_store = 2'd0;
      imm       = '0;
      take      = 1'b0;
      case (opc)
         3'b000: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            reg_store = 2'd1;
            alu_op    = d.ir_in[14:12] + 3'd1;
         end
         3'b001: begin
            reg_write = 1'b1;
            alu_op    = 3'b001;
            reg_store = 2'd1;
            imm       = {{9{d.ir_in[15]}}, d.ir_in[15:9]};
         end
         3'b010: begin
            reg_write = 1'b1;
            mem_read  = 1'b1;
            alu_op    = 3'b001;
            imm       = {{9{d.ir_in[15]}}, d.ir_in[15:9]};
         end
         3'b011: begin
            mem_write = 1'b1;
            alu_op    = 3'b001;
            imm       = {{9{d.ir_in[15]}}, d.ir_in[15:9]};
         end
         3'b100: begin
            imm  = {{8{d.ir_in[15]}}, d.ir_in[15:12], d.ir_in[5:3], 1'b0};
            take = op_a == op_b;
         end
         3'b101: begin
            imm  = {{8{d.ir_in[15]}}, d.ir_in[15:12], d.ir_in[5:3], 1'b0};
            take = $signed(op_a) < $signed(op_b);
         end
         3'b110: begin
            imm  = {{5{d.ir_in[15]}}, d.ir_in[15:9], d.ir_in[5:3], 1'b0};
            take = 1'b1;
         end
         default: ;
      endcase
   end
   assign live     = reset & d.RB_write;
   assign d.RegWrite = live & reg_write;
   assign d.MemWrite = live & mem_write;
   assign d.MemRead  = live & mem_read;
   assign d.jump     = ~(live & take);
   assign d.ALUSrc   = reset & alu_src;
   assign d.ALUOp    = reset ? alu_op : 3'b000;
   assign d.RegStore = reset ? reg_store : 2'd0;
   assign d.OPCP2    = reset ? d.IPCP2 : '0;
   assign d.Arg1     = reset ? rf_q[d.ir_in[8:6]] : '0;
   assign d.Arg2     = reset ? rf_q[d.ir_in[11:9]] : '0;
   assign d.Arg3     = reset ? rf_q[d.ir_in[5:3]] : '0;
   assign d.Imm      = reset ? imm : '0;
   assign d.Rs1      = reset ? d.ir_in[8:6] : 3'd0;
   assign d.Rs2      = reset ? d.ir_in[11:9] : 3'd0;
   assign d.Rd       = reset ? d.ir_in[5:3] : 3'd0;
   assign d.new_pc   = reset ? d.pc_in + imm : '0;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage against an arithmetic reference model
module tb_decode_stage;
   typedef struct packed {
      logic        rw;
      logic        src;
      logic        mw;
      logic        mr;
      logic [2:0]  op;
      logic [1:0]  rs;
      logic [15:0] opc2;
      logic [15:0] a1;
      logic [15:0] a2;
      logic [15:0] a3;
      logic [15:0] imm;
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic [2:0]  rd;
      logic [15:0] npc;
      logic        j;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] mrf [8];
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int passed = 0;
   decode_stage_if bus();
   decode_stage dut (.clk(clk), .reset(reset), .d(bus));
   always #5 clk = ~clk;
   function automatic int opnd(input logic [1:0] s, input logic [2:0] r);
      if (s == 2'd0) return int'($signed(bus.comparatorMuxForwardMEM));
      if (s == 2'd1) return int'($signed(bus.comparatorMuxForwardWB));
      return int'($signed(mrf[r]));
   endfunction
   function automatic exp_t predict();
      exp_t x;
      int v;
      int im;
      logic [2:0] kind;
      x = '0;
      x.j = 1'b1;
      im = 0;
      if (!reset) return x;
      kind = bus.ir_in[2:0];
      x.opc2 = bus.IPCP2;
      x.r1 = bus.ir_in[8:6];
      x.r2 = bus.ir_in[11:9];
      x.rd = bus.ir_in[5:3];
      x.a1 = mrf[x.r1];
      x.a2 = mrf[x.r2];
      x.a3 = mrf[x.rd];
      if (kind == 3'd0) begin
         x.rw = 1'b1;
         x.src = 1'b1;
         x.rs = 2'd1;
         x.op = 3'((int'(bus.ir_in[14:12]) + 1) % 8);
      end else if (kind <= 3'd3) begin
         v = int'(bus.ir_in[15:9]);
         im = v >= 64 ? v - 128 : v;
         x.op = 3'd1;
         x.rw = kind != 3'd3;
         x.mr = kind == 3'd2;
         x.mw = kind == 3'd3;
         x.rs = kind == 3'd1 ? 2'd1 : 2'd0;
      end else if (kind <= 3'd5) begin
         v = int'(bus.ir_in[15:12]) * 8 + int'(bus.ir_in[5:3]);
         im = 2 * (v >= 64 ? v - 128 : v);
         if (kind == 3'd4) x.j = (opnd(bus.comparatorMux1Control, x.r1) == opnd(bus.comparatorMux2Control, x.r2)) ? 1'b0 : 1'b1;
         else x.j = (opnd(bus.comparatorMux1Control, x.r1) < opnd(bus.comparatorMux2Control, x.r2)) ? 1'b0 : 1'b1;
      end else if (kind == 3'd6) begin
         v = int'(bus.ir_in[15:9]) * 8 + int'(bus.ir_in[5:3]);
         im = 2 * (v >= 512 ? v - 1024 : v);
         x.j = 1'b0;
      end
      x.imm = 16'(im);
      x.npc = 16'(int'(bus.pc_in) + im);
      if (!bus.RB_write) begin
         x.rw = 1'b0;
         x.mw = 1'b0;
         x.mr = 1'b0;
         x.j = 1'b1;
      end
      return x;
   endfunction
   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act === want) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, want);
   endtask
   task automatic wr(input int r, input int v);
      bus.rf_write = 1'b1;
      bus.loadAddr = 3'(r);
      bus.loadData = 16'(v);
      @(posedge clk);
      #1;
      bus.rf_write = 1'b0;
      if (reset && r != 0) mrf[r] = 16'(v);
   endtask
   task automatic apply(input logic [15:0] ir, input logic [15:0] pc = 16'h0100,
                        input logic [1:0] m1 = 2'd2, input logic [1:0] m2 = 2'd2,
                        input logic [15:0] fm = 16'h0, input logic [15:0] fw = 16'h0,
                        input logic rb = 1'b1);
      bus.ir_in = ir;
      bus.pc_in = pc;
      bus.IPCP2 = pc + 16'd2;
      bus.comparatorMux1Control = m1;
      bus.comparatorMux2Control = m2;
      bus.comparatorMuxForwardMEM = fm;
      bus.comparatorMuxForwardWB = fw;
      bus.RB_write = rb;
      q.push_back(predict());
      @(posedge clk);
      #1;
   endtask
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("RegWrite", 16'(bus.RegWrite), 16'(e.rw));
            chk("ALUSrc", 16'(bus.ALUSrc), 16'(e.src));
            chk("MemWrite", 16'(bus.MemWrite), 16'(e.mw));
            chk("MemRead", 16'(bus.MemRead), 16'(e.mr));
            chk("ALUOp", 16'(bus.ALUOp), 16'(e.op));
            chk("RegStore", 16'(bus.RegStore), 16'(e.rs));
            chk("OPCP2", bus.OPCP2, e.opc2);
            chk("Arg1", bus.Arg1, e.a1);
            chk("Arg2", bus.Arg2, e.a2);
            chk("Arg3", bus.Arg3, e.a3);
            chk("Imm", bus.Imm, e.imm);
            chk("Rs1", 16'(bus.Rs1), 16'(e.r1));
            chk("Rs2", 16'(bus.Rs2), 16'(e.r2));
            chk("Rd", 16'(bus.Rd), 16'(e.rd));
            chk("new_pc", bus.new_pc, e.npc);
            chk("jump", 16'(bus.jump), 16'(e.j));
         end
      end
   end
   initial begin
      for (int i = 0; i < 8; i++) mrf[i] = '0;
      bus.ir_in = 16'h0007;
      bus.pc_in = '0;
      bus.IPCP2 = '0;
      bus.rf_write = 1'b0;
      bus.loadAddr = '0;
      bus.loadData = '0;
      bus.RB_write = 1'b1;
      bus.comparatorMux1Control = 2'd2;
      bus.comparatorMux2Control = 2'd2;
      bus.comparatorMuxForwardMEM = '0;
      bus.comparatorMuxForwardWB = '0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      wr(4, 16'h7777);
      apply(16'h1D60);
      reset = 1'b1;
      apply(16'h1D60);
      wr(5, 16);
      wr(6, 10);
      wr(4, -8);
      apply(16'h1D60, 16'h0200);
      apply(16'h1961, 16'h0204);
      apply(16'h1562, 16'h0206);
      apply(16'h1563, 16'h0208);
      wr(5, 50);
      wr(6, 60);
      apply(16'hFD74, 16'h0300);
      apply(16'h0D4D, 16'h0302);
      wr(5, 60);
      apply(16'h0D4C, 16'h0304);
      apply(16'hFD5D, 16'h0306);
      apply(16'hFA8E, 16'h1000);
      wr(5, 0);
      apply(16'h0D4C, 16'h0400, 2'd0, 2'd2, 16'd60, 16'd0);
      apply(16'h0D4C, 16'h0400, 2'd0, 2'd2, 16'd60, 16'd0, 1'b0);
      apply(16'h1D60, 16'h0402, 2'd2, 2'd2, 16'd0, 16'd0, 1'b0);
      apply(16'hFA8E, 16'h0002, 2'd2, 2'd2, 16'd0, 16'd0, 1'b0);
      wr(0, 99);
      apply(16'h0000, 16'hFFFE);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 7), $urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom);
         if (n == 200) begin
            reset = 1'b0;
            for (int i = 0; i < 8; i++) mrf[i] = '0;
            apply(16'h1D60);
            wr(4, 16'h1234);
            reset = 1'b1;
            apply(16'h1D60);
         end
         apply(16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
               16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), $urandom_range(0, 7) != 0);
      end
      for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
